// File: rtl/button_debounce.sv
// Button debouncer with a small memory-mapped status/interrupt register block.
// Latency: a clean raw step reaches buttons_out DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; the bus is always ready (ready_out = sel_in), zero wait states.
// Optional feature: define BUTTON_DEBOUNCE_IRQ_EN to build the IRQ_MASK register and irq_out logic.
//
// Register map (address_in[3:2]):
//   0x0 STATE    RO   stable (debounced) levels
//   0x4 PRESS    W1C  set on an accepted 0->1 transition
//   0x8 RELEASE  W1C  set on an accepted 1->0 transition
//   0xC IRQ_MASK RW   only with BUTTON_DEBOUNCE_IRQ_EN, otherwise reads 0

module button_debounce #(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  output logic [BUTTONCOUNT-1:0] buttons_out,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic [31:0]            read_value_out,
  output logic                   ready_out,
  output logic                   irq_out
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 bits are enough.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] REG_STATE   = 2'd0;
  localparam logic [1:0] REG_PRESS   = 2'd1;
  localparam logic [1:0] REG_RELEASE = 2'd2;
  localparam logic [1:0] REG_MASK    = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchronizer, debounce state
  // ---------------------------------------------------------------------------
  logic [BUTTONCOUNT-1:0] r_sync1;
  logic [BUTTONCOUNT-1:0] r_sync2;
  logic [BUTTONCOUNT-1:0] r_stable;
  logic [CW-1:0]          r_cnt [BUTTONCOUNT];

  logic [BUTTONCOUNT-1:0] w_differ;
  logic [BUTTONCOUNT-1:0] w_accept;
  logic [BUTTONCOUNT-1:0] w_rise;
  logic [BUTTONCOUNT-1:0] w_fall;

  // Two-flop synchronizer on every raw pad level before any other logic sees it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= buttons_in;
      r_sync2 <= r_sync1;
    end
  end

  // A level change is accepted when it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive edges, i.e. the counter already sits at its last value.
  always_comb begin
    w_differ = r_sync2 ^ r_stable;
    w_accept = '0;
    for (int i = 0; i < BUTTONCOUNT; i++) begin
      w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_LAST);
    end
    w_rise = w_accept & r_sync2;
    w_fall = w_accept & ~r_sync2;
  end

  // Per-button qualification counters: count while differing, clear on match or accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUTTONCOUNT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BUTTONCOUNT; i++) begin
        if (!w_differ[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Stable levels take the synchronized level only on accepted bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= '0;
    end else begin
      r_stable <= (r_stable & ~w_accept) | (r_sync2 & w_accept);
    end
  end

  assign buttons_out = r_stable;

  // ---------------------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------------------
  logic                   w_wr;
  logic [1:0]             w_reg_idx;
  logic [31:0]            w_lane;
  logic [BUTTONCOUNT-1:0] w_wbits;
  logic [BUTTONCOUNT-1:0] w_clr_press;
  logic [BUTTONCOUNT-1:0] w_clr_release;

  // Byte-lane expansion of the write mask; only enabled lanes may change state.
  always_comb begin
    w_wr      = sel_in && (write_mask_in != 4'd0);
    w_reg_idx = address_in[3:2];
    w_lane    = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}},
                 {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
    w_wbits   = write_value_in[BUTTONCOUNT-1:0] & w_lane[BUTTONCOUNT-1:0];
    w_clr_press   = (w_wr && (w_reg_idx == REG_PRESS))   ? w_wbits : '0;
    w_clr_release = (w_wr && (w_reg_idx == REG_RELEASE)) ? w_wbits : '0;
  end

  // ---------------------------------------------------------------------------
  // Pending registers (W1C, a same-edge set beats the clear)
  // ---------------------------------------------------------------------------
  logic [BUTTONCOUNT-1:0] r_press;
  logic [BUTTONCOUNT-1:0] r_release;

  // Press/release pending bits: clear first, then OR in new events so the set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= (r_press   & ~w_clr_press)   | w_rise;
      r_release <= (r_release & ~w_clr_release) | w_fall;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt mask and request
  // ---------------------------------------------------------------------------
  logic [BUTTONCOUNT-1:0] w_mask_rd;

`ifdef BUTTON_DEBOUNCE_IRQ_EN
  logic [BUTTONCOUNT-1:0] r_irq_mask;
  logic                   r_irq;

  // IRQ_MASK is plain RW, byte-lane masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_mask <= '0;
    end else if (w_wr && (w_reg_idx == REG_MASK)) begin
      r_irq_mask <= (r_irq_mask & ~w_lane[BUTTONCOUNT-1:0]) | w_wbits;
    end
  end

  // Level interrupt, registered so it follows pending/mask changes one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |((r_press | r_release) & r_irq_mask);
    end
  end

  assign w_mask_rd = r_irq_mask;
  assign irq_out   = r_irq;
`else
  assign w_mask_rd = '0;
  assign irq_out   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: combinational, zero wait states, zero when not selected
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  // Register read mux with zero extension above BUTTONCOUNT.
  always_comb begin
    w_rdata = '0;
    if (sel_in) begin
      case (w_reg_idx)
        REG_STATE:   w_rdata[BUTTONCOUNT-1:0] = r_stable;
        REG_PRESS:   w_rdata[BUTTONCOUNT-1:0] = r_press;
        REG_RELEASE: w_rdata[BUTTONCOUNT-1:0] = r_release;
        default:     w_rdata[BUTTONCOUNT-1:0] = w_mask_rd;
      endcase
    end
  end

  assign read_value_out = w_rdata;
  assign ready_out      = sel_in;

  // Reads are side-effect free, so the strobe and undecoded address/data bits are
  // intentionally not consumed; fold them into one sink.
  logic w_unused;
  assign w_unused = ^{read_in, address_in[31:4], address_in[1:0], write_value_in, w_lane};

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  buttons_in;
  logic [3:0]  buttons_out;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        irq_out;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BUTTON_DEBOUNCE_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  button_debounce #(
    .BUTTONCOUNT(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .buttons_in(buttons_in),
    .buttons_out(buttons_out),
    .address_in(address_in),
    .sel_in(sel_in),
    .read_in(read_in),
    .write_mask_in(write_mask_in),
    .write_value_in(write_value_in),
    .read_value_out(read_value_out),
    .ready_out(ready_out),
    .irq_out(irq_out)
  );

  // Advance n edges, leaving time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Combinational read between edges; takes 2 time units, no clock edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address_in    = a;
    sel_in        = 1'b1;
    read_in       = 1'b1;
    write_mask_in = 4'h0;
    #1;
    d = read_value_out;
    sel_in  = 1'b0;
    read_in = 1'b0;
    #1;
  endtask

  // Write that lands on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] v);
    address_in     = a;
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = m;
    write_value_in = v;
    @(posedge clk);
    #1;
    sel_in         = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'h0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset = 1'b0;
    buttons_in = 4'hF;
    sel_in = 1'b1;
    address_in = 32'h4;
    tick(3);
    n_cmp++; if (buttons_out !== 4'h0) begin n_bad++; $display("FAIL rst_out: got %h want 0", buttons_out); end
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", irq_out); end
    n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready_sel1: got %b want 1", ready_out); end
    n_cmp++; if (read_value_out !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", read_value_out); end
    sel_in = 1'b0;
    #1;
    n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL rst_ready_sel0: got %b want 0", ready_out); end
    buttons_in = 4'h0;
    reset = 1'b1;
    tick(8);
    n_cmp++; if (buttons_out !== 4'h0) begin n_bad++; $display("FAIL idle_out: got %h want 0", buttons_out); end
    bus_read(32'h0, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL idle_state: got %h want 0", rd); end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL idle_press: got %h want 0", rd); end
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL idle_release: got %h want 0", rd); end
  endtask

  task automatic test_press_latency;
    logic [31:0] rd;
    buttons_in = 4'b0010;
    tick(5);
    n_cmp++; if (buttons_out !== 4'b0000) begin n_bad++; $display("FAIL lat_edge5: got %h want 0", buttons_out); end
    tick(1);
    n_cmp++; if (buttons_out !== 4'b0010) begin n_bad++; $display("FAIL lat_edge6: got %h want 2", buttons_out); end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL lat_press: got %h want 2", rd); end
    bus_read(32'h0, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL lat_state: got %h want 2", rd); end
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL lat_release: got %h want 0", rd); end
  endtask

  task automatic test_glitch;
    logic [31:0] rd;
    buttons_in = 4'b0011;
    tick(3);
    buttons_in = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_cmp++; if (buttons_out !== 4'b0010) begin n_bad++; $display("FAIL glitch_out cyc%0d: got %h want 2", i, buttons_out); end
    end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL glitch_press: got %h want 2", rd); end
  endtask

  task automatic test_w1c;
    logic [31:0] rd;
    bus_write(32'h4, 4'b1110, 32'h2);
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL w1c_lane_off: got %h want 2", rd); end
    bus_write(32'h0, 4'hF, 32'hF);
    bus_read(32'h0, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL state_ro: got %h want 2", rd); end
    bus_write(32'h4, 4'b0001, 32'h2);
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL w1c_clear: got %h want 0", rd); end
    buttons_in = 4'b0000;
    tick(6);
    n_cmp++; if (buttons_out !== 4'b0000) begin n_bad++; $display("FAIL rel_out: got %h want 0", buttons_out); end
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL rel_pending: got %h want 2", rd); end
    bus_write(32'h8, 4'b0001, 32'h2);
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rel_clear: got %h want 0", rd); end
    // New press whose accept edge coincides with a W1C of the same bit.
    buttons_in = 4'b0010;
    tick(5);
    bus_write(32'h4, 4'b0001, 32'h2);
    n_cmp++; if (buttons_out !== 4'b0010) begin n_bad++; $display("FAIL coll_out: got %h want 2", buttons_out); end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL coll_set_wins: got %h want 2", rd); end
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    bus_write(32'h4, 4'b0001, 32'h2);
    buttons_in = 4'b0110;
    tick(6);
    bus_write(32'h4, 4'b0001, 32'h4);
    bus_write(32'hC, 4'b0001, 32'h4);
    bus_read(32'hC, rd);
    n_cmp++; if (rd !== (IRQ_BUILD ? 32'h4 : 32'h0)) begin n_bad++; $display("FAIL mask_rd: got %h want %h", rd, IRQ_BUILD ? 32'h4 : 32'h0); end
    tick(1);
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_idle: got %b want 0", irq_out); end
    buttons_in = 4'b0010;
    tick(6);
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_pre: got %b want 0", irq_out); end
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h4) begin n_bad++; $display("FAIL irq_rel_pending: got %h want 4", rd); end
    tick(1);
    n_cmp++; if (irq_out !== IRQ_BUILD) begin n_bad++; $display("FAIL irq_set: got %b want %b", irq_out, IRQ_BUILD); end
    bus_write(32'h8, 4'b0001, 32'h4);
    n_cmp++; if (irq_out !== IRQ_BUILD) begin n_bad++; $display("FAIL irq_hold: got %b want %b", irq_out, IRQ_BUILD); end
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL irq_rel_clear: got %h want 0", rd); end
    tick(1);
    n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_drop: got %b want 0", irq_out); end
    if (!IRQ_BUILD) begin
      bus_write(32'hC, 4'hF, 32'hFFFF_FFFF);
      bus_read(32'hC, rd);
      n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mask_absent: got %h want 0", rd); end
    end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] rd;
    buttons_in = 4'b0000;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    buttons_in = 4'b1000;
    tick(4);
    #3;
    reset = 1'b0;
    #1;
    n_cmp++; if (buttons_out !== 4'h0) begin n_bad++; $display("FAIL mid_rst_out: got %h want 0", buttons_out); end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_rst_rdata: got %h want 0", rd); end
    n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", ready_out); end
    reset = 1'b1;
    tick(5);
    n_cmp++; if (buttons_out !== 4'h0) begin n_bad++; $display("FAIL requal_edge5: got %h want 0", buttons_out); end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL requal_press5: got %h want 0", rd); end
    tick(1);
    n_cmp++; if (buttons_out !== 4'b1000) begin n_bad++; $display("FAIL requal_edge6: got %h want 8", buttons_out); end
    bus_read(32'h4, rd);
    n_cmp++; if (rd !== 32'h8) begin n_bad++; $display("FAIL requal_press6: got %h want 8", rd); end
    bus_read(32'h8, rd);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL requal_release: got %h want 0", rd); end
  endtask

  initial begin
    reset          = 1'b0;
    buttons_in     = 4'h0;
    address_in     = 32'h0;
    sel_in         = 1'b0;
    read_in        = 1'b0;
    write_mask_in  = 4'h0;
    write_value_in = 32'h0;
    test_reset();
    test_press_latency();
    test_glitch();
    test_w1c();
    test_irq();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
- REQ-001 The block SHALL have parameter BUTTONCOUNT, default 4: number of raw button inputs, 1..32.
- REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before accepting a level change, >=2.
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all state.
- REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-005 The block SHALL have port buttons_in, input, BUTTONCOUNT bits: raw, asynchronous pad levels.
- REQ-006 The block SHALL have port buttons_out, output, BUTTONCOUNT bits: debounced levels that feed the SoC buttons port.
- REQ-007 The block SHALL have port address_in, input, 32 bits: bus address, of which only bits [3:2] are decoded.
- REQ-008 The block SHALL have ports sel_in (input, 1), read_in (input, 1), write_mask_in (input, 4) and write_value_in (input, 32): bus select, read strobe, byte-lane write mask and write data.
- REQ-009 The block SHALL have ports read_value_out (output, 32) and ready_out (output, 1): read data and bus ready.
- REQ-010 The block SHALL have port irq_out, output, 1 bit: level interrupt request.

Function
- REQ-011 Each input SHALL pass through a two-flop synchronizer before any other logic.
- REQ-012 Each button SHALL have a counter of width $clog2(DEBOUNCE_CYCLES); the counter SHALL increment on every edge where the synchronized level differs from the stable level, and SHALL clear when the levels match.
- REQ-013 The stable bit SHALL take the synchronized level, and the counter SHALL clear, on the edge where the levels differ and the counter equals DEBOUNCE_CYCLES-1.
- REQ-014 A clean raw step SHALL therefore appear on buttons_out exactly DEBOUNCE_CYCLES+2 edges after its first sampling edge.
- REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.
- REQ-016 A stable 0->1 transition SHALL set the press-pending bit for that button; a stable 1->0 transition SHALL set the release-pending bit.
- REQ-017 The register map SHALL be: 0x0 STATE (RO, stable levels); 0x4 PRESS (W1C); 0x8 RELEASE (W1C); 0xC IRQ_MASK (RW, only when the REQ-025 macro is set).
- REQ-018 ready_out SHALL equal sel_in, with zero wait states for both read and write.
- REQ-019 read_value_out SHALL be zero-extended register data when sel_in=1, and 0 otherwise.
- REQ-020 A write SHALL occur when sel_in=1 and write_mask_in is nonzero, and SHALL affect only bits within the enabled byte lanes.
- REQ-021 If a pending bit is set and W1C-cleared on the same edge, the set SHALL win.
- REQ-022 Writes to STATE and to unmapped offsets SHALL be ignored.

Reset
- REQ-023 While reset=0, all synchronizer flops, stable bits, counters, pending bits and IRQ_MASK SHALL be 0.
- REQ-024 While reset=0, buttons_out, irq_out and read_value_out SHALL be 0 and ready_out SHALL follow sel_in; reset asserted mid-count SHALL discard the count with no pending set.

Configuration
- REQ-025 Macro BUTTON_DEBOUNCE_IRQ_EN defined: IRQ_MASK is implemented, and irq_out = |((PRESS | RELEASE) & IRQ_MASK), registered one edge after the pending or mask change.
- REQ-026 Macro BUTTON_DEBOUNCE_IRQ_EN undefined: no mask register, offset 0xC reads 0 and ignores writes, and irq_out is constant 0.

Verification (BUTTONCOUNT=4, DEBOUNCE_CYCLES=4)
- REQ-027 The bench SHALL cover: reset release, raw 4'b0000 -> buttons_out=0, STATE=0, PRESS=0, RELEASE=0.
- REQ-028 The bench SHALL cover: buttons_in[1] steps 0->1 and holds -> buttons_out[1]=1 exactly 6 edges later, and PRESS reads 0x2.
- REQ-029 The bench SHALL cover: buttons_in[0] high for 3 cycles, then low -> buttons_out[0] never changes, and PRESS[0] stays 0.
- REQ-030 The bench SHALL cover: PRESS=0x2, write 0x2 to 0x4 -> PRESS=0; then a new press and a W1C landing on the same edge -> PRESS=0x2.
- REQ-031 The bench SHALL cover: with BUTTON_DEBOUNCE_IRQ_EN, IRQ_MASK=0x4 and button 2 released -> irq_out=1; write 0x4 to 0x8 -> irq_out=0 one edge later; without the macro, 0xC reads 0 and irq_out=0.
- REQ-032 The bench SHALL cover: reset pulsed while a counter is at 2 -> after release, output and pending stay 0 until a full 6-edge qualification completes.
